noc_output_arbiter: RTL and testbench

- Per-output-port arbiter/scheduler for the mesh router.
- Shares one router output link among N_PORT input-side requesters (Local, N, E, S, W input buffers).
- Uses round-robin arbitration with packet-level locking: a grant is held from head flit to tail flit.
- Drives the registered output flit and val toward the downstream output controller, and obeys its full back-pressure.

---
 rtl/noc_output_arbiter.sv | 140 ++++++++++++++
 tb/tb_noc_output_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/noc_output_arbiter.sv
// Per-output-port round-robin arbiter with packet-level locking for the mesh router.
// All outputs are registered; a lock is held from head to tail flit or until the owner times out.

module noc_output_arbiter #(
   parameter int unsigned N_PORT     = 5,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned IDX_W      = 3,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_PORT-1:0]            req,
   input  logic [N_PORT-1:0]            tail,
   input  logic [N_PORT*DATA_WIDTH-1:0] Data_in,
   input  logic                         full,
   output logic [N_PORT-1:0]            grant,
   output logic [DATA_WIDTH-1:0]        Data_out,
   output logic                         val,
   output logic [IDX_W-1:0]             owner,
   output logic                         busy
);

   typedef enum logic {StIdle, StLock} state_e;

   state_e                  state_q, state_d;
   logic [N_PORT-1:0]       grant_q, grant_d;
   logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
   logic                    val_q, val_d;
   logic [IDX_W-1:0]        owner_q, owner_d;
   logic                    busy_q, busy_d;
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [7:0]              idle_cnt_q, idle_cnt_d;

   logic [DATA_WIDTH-1:0]   flit [N_PORT];
   logic [IDX_W:0]          cand;
   logic [IDX_W-1:0]        winner;
   logic                    found;
   logic [IDX_W-1:0]        next_ptr;
   logic                    owner_req;
   logic                    xfer;
   logic                    timed_out;

   always_comb begin
      for (int i = 0; i < N_PORT; i++) begin
         flit[i] = Data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // First requester at or after rr_ptr, wrapping modulo N_PORT.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int unsigned i = 0; i < N_PORT; i++) begin
         cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
         if (cand >= (IDX_W+1)'(N_PORT)) begin
            cand = cand - (IDX_W+1)'(N_PORT);
         end
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand[IDX_W-1:0];
         end
      end
   end

   assign next_ptr  = (owner_q == IDX_W'(N_PORT - 1)) ? '0 : owner_q + 1'b1;
   assign owner_req = req[owner_q];
   assign xfer      = owner_req & ~full;
   assign timed_out = ~owner_req && ((idle_cnt_q + 8'd1) == 8'(TIMEOUT));

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      data_out_d = data_out_q;
      val_d      = 1'b0;
      owner_d    = owner_q;
      busy_d     = busy_q;
      rr_ptr_d   = rr_ptr_q;
      idle_cnt_d = idle_cnt_q;
      unique case (state_q)
         StIdle: begin
            idle_cnt_d = '0;
            if (found) begin
               state_d = StLock;
               grant_d = {{(N_PORT-1){1'b0}}, 1'b1} << winner;
               owner_d = winner;
               busy_d  = 1'b1;
            end
         end
         StLock: begin
            if (xfer) begin
               data_out_d = flit[owner_q];
               val_d      = 1'b1;
            end
            // Stalls on full with a pending flit are not idleness.
            idle_cnt_d = owner_req ? '0 : idle_cnt_q + 8'd1;
            if ((xfer && tail[owner_q]) || timed_out) begin
               state_d    = StIdle;
               grant_d    = '0;
               owner_d    = '0;
               busy_d     = 1'b0;
               rr_ptr_d   = next_ptr;
               idle_cnt_d = '0;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         grant_q    <= '0;
         data_out_q <= '0;
         val_q      <= 1'b0;
         owner_q    <= '0;
         busy_q     <= 1'b0;
         rr_ptr_q   <= '0;
         idle_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         data_out_q <= data_out_d;
         val_q      <= val_d;
         owner_q    <= owner_d;
         busy_q     <= busy_d;
         rr_ptr_q   <= rr_ptr_d;
         idle_cnt_q <= idle_cnt_d;
      end
   end

   assign grant    = grant_q;
   assign Data_out = data_out_q;
   assign val      = val_q;
   assign owner    = owner_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed bench for noc_output_arbiter: reset, packets, round-robin, back-pressure,
// lock timeout and reset mid-packet, checked with immediate assertions.

module tb_noc_output_arbiter;

   localparam int unsigned N_PORT     = 5;
   localparam int unsigned DATA_WIDTH = 8;
   localparam int unsigned IDX_W      = 3;
   localparam int unsigned TIMEOUT    = 15;

   logic                         clk;
   logic                         rst;
   logic [N_PORT-1:0]            req;
   logic [N_PORT-1:0]            tail;
   logic [N_PORT*DATA_WIDTH-1:0] Data_in;
   logic                         full;
   logic [N_PORT-1:0]            grant;
   logic [DATA_WIDTH-1:0]        Data_out;
   logic                         val;
   logic [IDX_W-1:0]             owner;
   logic                         busy;

   int passed;
   int total;

   noc_output_arbiter #(
      .N_PORT    (N_PORT),
      .DATA_WIDTH(DATA_WIDTH),
      .IDX_W     (IDX_W),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .tail    (tail),
      .Data_in (Data_in),
      .full    (full),
      .grant   (grant),
      .Data_out(Data_out),
      .val     (val),
      .owner   (owner),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_grant"}, 32'(grant), 32'h0);
      chk({tag, "_val"}, 32'(val), 32'h0);
      chk({tag, "_data"}, 32'(Data_out), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
      chk({tag, "_owner"}, 32'(owner), 32'h0);
   endtask

   task automatic set_flit(input int port, input logic [7:0] d);
      Data_in[port*DATA_WIDTH +: DATA_WIDTH] = d;
   endtask

   initial begin
      passed  = 0;
      total   = 0;
      rst     = 1'b0;
      req     = '0;
      tail    = '0;
      Data_in = '0;
      full    = 1'b0;

      // Reset then idle: asynchronous clear before any clock edge
      #2 rst = 1'b1;
      #1 chk_zero("rst_async");
      @(negedge clk) rst = 1'b0;
      repeat (5) tick();
      chk_zero("rst_idle");

      // Single requester, 3-flit packet on port 2
      req = 5'b00100;
      set_flit(2, 8'hA1);
      tick();
      chk("p2_grant", 32'(grant), 32'h04);
      chk("p2_owner", 32'(owner), 32'd2);
      chk("p2_busy", 32'(busy), 32'd1);
      chk("p2_val0", 32'(val), 32'd0);
      tick();
      chk("p2_f1_val", 32'(val), 32'd1);
      chk("p2_f1_data", 32'(Data_out), 32'hA1);
      set_flit(2, 8'hA2);
      tick();
      chk("p2_f2_data", 32'(Data_out), 32'hA2);
      set_flit(2, 8'hA3);
      tail = 5'b00100;
      tick();
      chk("p2_f3_val", 32'(val), 32'd1);
      chk("p2_f3_data", 32'(Data_out), 32'hA3);
      chk("p2_rel_grant", 32'(grant), 32'h0);
      chk("p2_rel_busy", 32'(busy), 32'd0);
      chk("p2_rr_ptr", 32'(dut.rr_ptr_q), 32'd3);
      req  = '0;
      tail = '0;
      tick();
      chk("p2_idle_val", 32'(val), 32'd0);
      chk("p2_idle_hold", 32'(Data_out), 32'hA3);

      // Round-robin: everyone requesting single-flit packets from rr_ptr=0
      rst = 1'b1;
      #2 rst = 1'b0;
      req  = 5'b11111;
      tail = 5'b11111;
      for (int p = 0; p < N_PORT; p++) set_flit(p, 8'(8'h10 + p));
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("rr%0d_grant", i), 32'(grant), 32'(1 << (i % N_PORT)));
         chk($sformatf("rr%0d_owner", i), 32'(owner), 32'(i % N_PORT));
         chk($sformatf("rr%0d_val0", i), 32'(val), 32'd0);
         tick();
         chk($sformatf("rr%0d_val", i), 32'(val), 32'd1);
         chk($sformatf("rr%0d_data", i), 32'(Data_out), 32'(8'h10 + (i % N_PORT)));
         chk($sformatf("rr%0d_bubble", i), 32'(grant), 32'h0);
      end
      req  = '0;
      tail = '0;
      tick();

      // Back-pressure during port 1's packet (rr_ptr now 1)
      req = 5'b00010;
      set_flit(1, 8'hB1);
      tick();
      chk("bp_grant", 32'(grant), 32'h02);
      tick();
      chk("bp_f1_data", 32'(Data_out), 32'hB1);
      set_flit(1, 8'hB2);
      full = 1'b1;
      for (int i = 0; i < 18; i++) begin
         tick();
         chk($sformatf("bp_full%0d_val", i), 32'(val), 32'd0);
         chk($sformatf("bp_full%0d_data", i), 32'(Data_out), 32'hB1);
         chk($sformatf("bp_full%0d_grant", i), 32'(grant), 32'h02);
      end
      full = 1'b0;
      tick();
      chk("bp_f2_val", 32'(val), 32'd1);
      chk("bp_f2_data", 32'(Data_out), 32'hB2);
      set_flit(1, 8'hB3);
      tail = 5'b00010;
      tick();
      chk("bp_f3_data", 32'(Data_out), 32'hB3);
      chk("bp_rel_grant", 32'(grant), 32'h0);
      req  = '0;
      tail = '0;
      tick();

      // Lock timeout: port 3 owns then drops req without tail (rr_ptr now 2)
      req = 5'b01000;
      tick();
      chk("to_grant", 32'(grant), 32'h08);
      chk("to_owner", 32'(owner), 32'd3);
      req = 5'b10001;
      repeat (TIMEOUT - 1) tick();
      chk("to_busy_hold", 32'(busy), 32'd1);
      chk("to_grant_hold", 32'(grant), 32'h08);
      tick();
      chk("to_busy_rel", 32'(busy), 32'd0);
      chk("to_grant_rel", 32'(grant), 32'h0);
      tick();
      chk("to_next_grant", 32'(grant), 32'h10);
      chk("to_next_owner", 32'(owner), 32'd4);

      // Reset mid-packet from port 0
      rst = 1'b1;
      #2 rst = 1'b0;
      req = 5'b00001;
      set_flit(0, 8'hC1);
      tick();
      chk("mr_grant", 32'(grant), 32'h01);
      tick();
      chk("mr_f1_data", 32'(Data_out), 32'hC1);
      set_flit(0, 8'hC2);
      tick();
      chk("mr_f2_data", 32'(Data_out), 32'hC2);
      set_flit(0, 8'hC3);
      #2 rst = 1'b1;
      #1 chk_zero("mr_async");
      #1 rst = 1'b0;
      req = 5'b00011;
      tick();
      chk("mr_regrant", 32'(grant), 32'h01);
      chk("mr_reowner", 32'(owner), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
